// File: rtl/fcs_frame_ctrl.sv
// Frame sequencer for the serial 802.15.4 FCS engine: streams MHR+payload bytes LSB first,
// captures the engine result after a one-cycle gap and appends it to the on-air bit stream.
module fcs_frame_ctrl #(
    parameter int MAX_LEN = 125,
    parameter int LEN_W   = 7
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             frame_start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             abort,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             fcs_start,
    output logic             fcs_data,
    input  logic [15:0]      fcs_reg,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_GAP    = 3'd3,
        ST_APPEND = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_C     = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       pf_q, pf_d;
    logic             pf_full_q, pf_full_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [15:0]      cap_q, cap_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             len_ok_s;
    logic             hs_s;
    logic             byte_ready_s;
    logic             tx_bit_s;

    // byte_cnt counts bytes still to be accepted from the source, so it excludes
    // both the byte in the shift register and any byte waiting in the prefetch buffer
    always_comb begin
        byte_ready_s = 1'b0;
        tx_bit_s     = 1'b0;
        case (state_q)
            ST_FETCH:  byte_ready_s = 1'b1;
            ST_SHIFT: begin
                byte_ready_s = !pf_full_q && (byte_cnt_q != {LEN_W{1'b0}});
                tx_bit_s     = shift_q[bit_cnt_q[2:0]];
            end
            ST_APPEND: tx_bit_s = cap_q[bit_cnt_q];
            default: begin
                byte_ready_s = 1'b0;
                tx_bit_s     = 1'b0;
            end
        endcase
    end

    assign len_ok_s   = (frame_len != {LEN_W{1'b0}}) && (frame_len <= MAX_LEN_C);
    assign hs_s       = byte_valid && byte_ready_s;
    assign byte_ready = byte_ready_s;
    assign fcs_start  = (state_q == ST_SHIFT);
    assign fcs_data   = (state_q == ST_SHIFT) ? tx_bit_s : 1'b0;
    assign tx_bit     = tx_bit_s;
    assign tx_valid   = (state_q == ST_SHIFT) || (state_q == ST_APPEND);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign err        = err_q;

    // Next-state and datapath update; abort overrides everything outside IDLE
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        pf_d       = pf_q;
        pf_full_d  = pf_full_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        cap_d      = cap_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            pf_d       = 8'h00;
            pf_full_d  = 1'b0;
            byte_cnt_d = {LEN_W{1'b0}};
            bit_cnt_d  = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        if (len_ok_s) begin
                            byte_cnt_d = frame_len;
                            state_d    = ST_FETCH;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (hs_s) begin
                        shift_d    = byte_data;
                        bit_cnt_d  = 4'd0;
                        byte_cnt_d = byte_cnt_q - ONE_C;
                        state_d    = ST_SHIFT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        if (pf_full_q) begin
                            shift_d   = pf_q;
                            pf_full_d = 1'b0;
                        end else if (byte_cnt_q != {LEN_W{1'b0}}) begin
                            // underrun: a byte arriving on this same edge is dropped
                            err_d      = 1'b1;
                            byte_cnt_d = {LEN_W{1'b0}};
                            state_d    = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (hs_s) begin
                            pf_d       = byte_data;
                            pf_full_d  = 1'b1;
                            byte_cnt_d = byte_cnt_q - ONE_C;
                        end else begin
                            pf_full_d = pf_full_q;
                        end
                    end
                end
                ST_GAP: begin
                    cap_d     = fcs_reg;
                    bit_cnt_d = 4'd0;
                    state_d   = ST_APPEND;
                end
                ST_APPEND: begin
                    if (bit_cnt_q == 4'd15) begin
                        bit_cnt_d = 4'd0;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            pf_q       <= 8'h00;
            pf_full_q  <= 1'b0;
            byte_cnt_q <= {LEN_W{1'b0}};
            bit_cnt_q  <= 4'd0;
            cap_q      <= 16'h0000;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            pf_q       <= pf_d;
            pf_full_q  <= pf_full_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            cap_q      <= cap_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_fcs_frame_ctrl.sv
// Directed bench for fcs_frame_ctrl with a serial CRC-16 (0x8408, LSB first) engine model
// on the fcs_start/fcs_data/fcs_reg pins and a reference 3-byte frame 02 00 6A.
module tb_fcs_frame_ctrl;

    localparam int LEN_W = 7;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             frame_start = 1'b0;
    logic [LEN_W-1:0] frame_len = 7'd0;
    logic             abort = 1'b0;
    logic [7:0]       byte_data = 8'h00;
    logic             byte_valid = 1'b0;
    logic             byte_ready;
    logic             fcs_start;
    logic             fcs_data;
    logic [15:0]      fcs_reg_s;
    logic             tx_bit;
    logic             tx_valid;
    logic             busy;
    logic             done;
    logic             err;

    int total = 0;
    int bad = 0;
    int byte_idx = 0;
    int avail = 0;

    fcs_frame_ctrl #(.MAX_LEN(125), .LEN_W(LEN_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .frame_len   (frame_len),
        .abort       (abort),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .fcs_start   (fcs_start),
        .fcs_data    (fcs_data),
        .fcs_reg     (fcs_reg_s),
        .tx_bit      (tx_bit),
        .tx_valid    (tx_valid),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    // Serial FCS engine: accumulates while start is high, clears otherwise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcs_reg_s <= 16'h0000;
        end else if (fcs_start) begin
            fcs_reg_s <= {1'b0, fcs_reg_s[15:1]} ^ ((fcs_reg_s[0] ^ fcs_data) ? 16'h8408 : 16'h0000);
        end else begin
            fcs_reg_s <= 16'h0000;
        end
    end

    function automatic logic [7:0] ref_byte(input int i);
        case (i)
            0:       return 8'h02;
            1:       return 8'h00;
            2:       return 8'h6A;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: note handshake before the edge, sample at edge+1, present next byte
    task automatic tick();
        logic hs;
        hs = byte_valid & byte_ready;
        @(posedge clock);
        #1;
        if (hs) byte_idx++;
        byte_valid = (byte_idx < avail);
        byte_data  = ref_byte(byte_idx);
    endtask

    task automatic start_frame(input logic [LEN_W-1:0] len);
        frame_start = 1'b1;
        frame_len   = len;
        tick();
        frame_start = 1'b0;
        frame_len   = 7'd0;
    endtask

    // Reference frame; stall = FETCH cycles with byte_valid low, abort_bit = APPEND bit to abort on (-1 none)
    task automatic run_ref(input string tag, input int stall, input int abort_bit);
        logic [23:0] data_bits;
        logic [23:0] fd_bits;
        logic [15:0] app_bits;
        logic        seq_ok;
        logic        stall_ok;
        logic        done_seen;
        byte_idx   = 0;
        avail      = (stall == 0) ? 3 : 0;
        byte_valid = 1'b0;
        byte_data  = ref_byte(0);
        seq_ok     = 1'b1;
        stall_ok   = 1'b1;
        data_bits  = 24'h0;
        fd_bits    = 24'h0;
        app_bits   = 16'h0;
        start_frame(7'd3);
        check_val({tag, "_busy_start"}, 32'(busy), 32'd1);
        check_val({tag, "_ready_start"}, 32'(byte_ready), 32'd1);
        for (int i = 0; i < stall; i++) begin
            if (tx_valid || fcs_start || !byte_ready) stall_ok = 1'b0;
            tick();
        end
        if (stall > 0) begin
            check_val({tag, "_stall_quiet"}, 32'(stall_ok), 32'd1);
            avail      = 3;
            byte_valid = 1'b1;
            byte_data  = ref_byte(0);
        end
        tick();
        check_val({tag, "_first_bit"}, 32'(tx_valid), 32'd1);
        for (int i = 0; i < 24; i++) begin
            data_bits[i] = tx_bit;
            fd_bits[i]   = fcs_data;
            if (!tx_valid || !fcs_start || done || err) seq_ok = 1'b0;
            tick();
        end
        check_val({tag, "_tx_bits"}, 32'(data_bits), 32'h006A0002);
        check_val({tag, "_fcs_bits"}, 32'(fd_bits), 32'h006A0002);
        check_val({tag, "_gap"}, 32'({tx_valid, fcs_start, busy}), 32'h1);
        tick();
        for (int i = 0; i < 16; i++) begin
            app_bits[i] = tx_bit;
            if (!tx_valid || fcs_start || done) seq_ok = 1'b0;
            if (i == abort_bit) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check_val({tag, "_abort_idle"}, 32'({busy, tx_valid, done, err}), 32'h0);
                check_val({tag, "_abort_pre_bits"}, 32'(app_bits[5:0]), 32'h24);
                done_seen = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    tick();
                    if (done || busy) done_seen = 1'b1;
                end
                check_val({tag, "_abort_no_done"}, 32'(done_seen), 32'd0);
                return;
            end
            tick();
        end
        check_val({tag, "_seq"}, 32'(seq_ok), 32'd1);
        check_val({tag, "_append"}, 32'(app_bits), 32'h79E4);
        check_val({tag, "_done"}, 32'({done, busy, tx_valid}), 32'h4);
        tick();
        check_val({tag, "_done_pulse"}, 32'({done, err}), 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_val("reset_outputs",
                  32'({busy, tx_valid, fcs_start, byte_ready, tx_bit, fcs_data, done, err}), 32'h0);
        reset_n = 1'b1;
        tick();
        check_val("idle_outputs",
                  32'({busy, tx_valid, fcs_start, byte_ready, done, err}), 32'h0);

        run_ref("ref", 0, -1);
        run_ref("stall", 3, -1);

        // Underrun: only the first byte is available until bit 7 of it
        byte_idx = 0;
        avail    = 1;
        start_frame(7'd3);
        tick();
        check_val("under_ready", 32'({tx_valid, byte_ready}), 32'h3);
        repeat (7) tick();
        avail      = 2;
        byte_valid = 1'b1;
        byte_data  = ref_byte(1);
        tick();
        avail      = 0;
        byte_valid = 1'b0;
        check_val("under_err", 32'({err, busy, fcs_start, tx_valid, done}), 32'h10);
        tick();
        check_val("under_err_pulse", 32'({err, busy, done}), 32'h0);

        // Illegal lengths
        start_frame(7'd0);
        check_val("len0_err", 32'({err, busy}), 32'h2);
        tick();
        check_val("len0_pulse", 32'({err, busy}), 32'h0);
        start_frame(7'd126);
        check_val("len126_err", 32'({err, busy}), 32'h2);
        tick();
        check_val("len126_pulse", 32'({err, busy}), 32'h0);

        // Maximum length accepted, then abort from FETCH
        avail = 0;
        start_frame(7'd125);
        check_val("len125_ok", 32'({err, busy}), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("fetch_abort", 32'({busy, err, done}), 32'h0);

        // frame_start beats abort in IDLE
        abort = 1'b1;
        start_frame(7'd3);
        abort = 1'b0;
        check_val("start_vs_abort", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        run_ref("abort", 0, 5);
        run_ref("post_abort", 0, -1);

        // Asynchronous reset in the middle of SHIFT
        byte_idx = 0;
        avail    = 3;
        start_frame(7'd3);
        repeat (4) tick();
        check_val("pre_reset_shift", 32'({busy, fcs_start, tx_valid}), 32'h7);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_reset",
                  32'({busy, tx_valid, fcs_start, byte_ready, tx_bit, fcs_data, done, err}), 32'h0);
        avail = 0;
        tick();
        reset_n = 1'b1;
        tick();
        check_val("post_reset_idle", 32'({busy, done, err}), 32'h0);
        run_ref("post_reset", 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fcs_frame_ctrl.md
# fcs_frame_ctrl

Sequencer that feeds an 802.15.4 frame (MHR + payload) byte-by-byte into the serial 16-bit FCS engine (FCS_16bit) and emits the complete on-air bit stream with the 16-bit FCS appended. It sits between the MAC byte source and the PHY bit serializer. It owns the engine's `start`/`data` pins and captures its `FCS_reg` result.

## Interface
- `MAX_LEN`, default 125: maximum frame_len in bytes (MHR + payload, FCS excluded).
- `LEN_W`, default 7: width of frame_len.

- `clock` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle request to send a frame; sampled only in IDLE.
- `frame_len` in LEN_W: byte count; sampled with frame_start; legal range 1..MAX_LEN.
- `abort` in 1: synchronous abort; highest priority after reset.
- `byte_data` in 8: next frame byte; transmitted LSB first.
- `byte_valid` in 1: byte_data valid.
- `byte_ready` out 1: controller accepts byte_data on cycles where valid & ready.
- `fcs_start` out 1: to engine `start`; high exactly while frame bits are shifted.
- `fcs_data` out 1: to engine `data`.
- `fcs_reg` in 16: engine `FCS_reg`.
- `tx_bit` out 1: serial output bit.
- `tx_valid` out 1: tx_bit valid this cycle.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last FCS bit.
- `err` out 1: one-cycle pulse on illegal length or underrun.

## Operation
- Datapath: 8-bit shift register, 1-byte prefetch buffer (with full flag), byte counter (LEN_W), bit counter (4 bits), 16-bit FCS capture register.
- States: IDLE, FETCH, SHIFT, GAP, APPEND.
- IDLE: frame_start with frame_len in 1..MAX_LEN -> latch len, go FETCH. frame_len 0 or >MAX_LEN -> err pulse, stay IDLE. frame_start outside IDLE is ignored.
- FETCH: byte_ready=1, fcs_start=0, tx_valid=0. A handshake loads the shift register, bit counter=0, and goes to SHIFT. FETCH waits indefinitely.
- SHIFT: fcs_start=1, tx_valid=1, fcs_data=tx_bit=shift[bit_cnt]. byte_ready = (prefetch empty) & (bytes still owed beyond the current one).
- At bit 7 of a non-final byte:
  - Prefetch full: move prefetch into the shift register, clear prefetch, and continue SHIFT with no bubble.
  - Prefetch empty: underrun. err pulse, go IDLE, fcs_start drops. A handshake in that same cycle is discarded.
- At bit 7 of the final byte: go GAP.
- GAP: one cycle, fcs_start=0, tx_valid=0. fcs_reg is captured at the end of GAP.
- APPEND: 16 cycles, tx_valid=1, fcs_start=0, tx_bit=cap[0] first through cap[15]. After bit 15: done pulse, go IDLE.
- abort in any non-IDLE state: next cycle in IDLE. Prefetch is cleared, no done, no err.

## Timing
- Reset values: all outputs 0, state IDLE, counters, prefetch and capture register cleared.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronously). The frame is lost and no done pulse is issued.
- frame_start at edge k -> byte_ready=1 from cycle k+1.
- First handshake at edge m -> first bit on tx_bit/fcs_data in cycle m+1.
- For an N-byte frame, tx_valid is high for 8N contiguous cycles, then low for 1 cycle (GAP), then high for 16 cycles.
- done is asserted in cycle m+8N+18. busy falls in that same cycle.
- fcs_start never drops mid-frame except on underrun or abort. The engine contract: it accumulates on each edge with start=1, and its fcs_reg is final in the cycle after start falls.
- Simultaneous abort and end of APPEND: abort wins, so done is suppressed.
- Simultaneous frame_start and abort in IDLE: the frame starts.

## Test plan
- Reference frame: frame_len=3, bytes 0x02, 0x00, 0x6A, always valid.
  - Required: 24 bits 0100_0000_0000_0000_0101_0110 on tx_bit, one GAP cycle, captured FCS = 0x79E4.
  - Appended bits 0,0,1,0,0,1,1,1,1,0,0,1,1,1,1,0, then done.
- Back-pressure: drop byte_valid for 3 cycles while in FETCH before the first byte -> no tx_valid until the handshake, identical output.
- Underrun: frame_len=3, second byte withheld until after bit 7 of the first byte -> err pulse, fcs_start low, return to IDLE, no done.
- Illegal length: frame_len=0, then frame_len=126 -> err pulse each time, busy stays 0.
- Abort on APPEND bit 5 -> IDLE next cycle, no done. A following legal frame produces the correct FCS.
- Async reset mid-SHIFT -> all outputs 0 immediately. After release, a normal frame completes correctly.
